tmds_encoder: RTL and testbench

Single-channel DVI/HDMI TMDS encoder: converts 8-bit pixel data, or a 2-bit control word, into a 10-bit DC-balanced symbol. It sits directly downstream of the video signal generator and the pixel pipeline, clocked by the same pixel clock. Three instances (B, G, R) feed the 10:1 serializers. Blue carries {vs, hs} as its control word; green and red carry 2'b00.

---
 rtl/tmds_encoder_if.sv | 25 ++
 rtl/tmds_encoder.sv | 121 ++++++++++++
 tb/tb_tmds_encoder.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/tmds_encoder_if.sv
// Pixel-side bundle for one TMDS channel: data/control/enable in,
// encoded symbol and running disparity out.
interface tmds_encoder_if;
    logic [7:0]        data_in;
    logic [1:0]        control_in;
    logic              ve_in;
    logic [9:0]        tmds_out;
    logic signed [4:0] cnt;

    modport master (
        output data_in,
        output control_in,
        output ve_in,
        input  tmds_out,
        input  cnt
    );

    modport slave (
        input  data_in,
        input  control_in,
        input  ve_in,
        output tmds_out,
        output cnt
    );
endinterface

// File: rtl/tmds_encoder.sv
// Single-channel DVI/HDMI TMDS encoder: stage 1 builds the
// transition-minimised q_m word, stage 2 applies DC balancing.
module tmds_encoder (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    tmds_encoder_if.slave bus
);
    logic [3:0] w_n1d;
    logic       w_xnor;
    logic [8:0] w_qm;

    logic [8:0] r_qm;
    logic       r_ve;
    logic [1:0] r_ctrl;

    logic [3:0] w_n1;
    logic [4:0] w_diff;
    logic [4:0] w_q8x2;
    logic [4:0] w_nq8x2;
    logic       w_cnt_zero;
    logic       w_bal;
    logic       w_case_a;
    logic       w_case_b;
    logic [9:0] w_sym;
    logic [4:0] w_cnt_nxt;

    logic [9:0] r_out;
    logic [4:0] r_cnt;

    always_comb begin
        w_n1d = '0;
        for (int i = 0; i < 8; i++)
            w_n1d = w_n1d + {3'b000, bus.data_in[i]};
    end

    assign w_xnor = (w_n1d > 4'd4) ||
                    ((w_n1d == 4'd4) && !bus.data_in[0]);

    always_comb begin : qm_calc
        logic [8:0] v;
        v    = '0;
        v[0] = bus.data_in[0];
        for (int i = 1; i < 8; i++)
            v[i] = w_xnor ? ~(v[i-1] ^ bus.data_in[i])
                          :  (v[i-1] ^ bus.data_in[i]);
        v[8] = ~w_xnor;
        w_qm = v;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_qm   <= '0;
            r_ve   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_qm   <= w_qm;
            r_ve   <= bus.ve_in;
            r_ctrl <= bus.control_in;
        end
    end

    always_comb begin
        w_n1 = '0;
        for (int i = 0; i < 8; i++)
            w_n1 = w_n1 + {3'b000, r_qm[i]};
    end

    // N1 - N0 = 2*N1 - 8, kept in 5-bit two's complement
    assign w_diff     = {w_n1, 1'b0} - 5'd8;
    assign w_q8x2     = {3'b000, r_qm[8], 1'b0};
    assign w_nq8x2    = {3'b000, ~r_qm[8], 1'b0};
    assign w_cnt_zero = (r_cnt == 5'd0);
    assign w_bal      = (w_diff == 5'd0);
    assign w_case_a   = w_cnt_zero || w_bal;
    assign w_case_b   = (!r_cnt[4] && !w_cnt_zero &&
                         !w_diff[4] && !w_bal) ||
                        (r_cnt[4] && w_diff[4]);

    always_comb begin
        w_sym     = '0;
        w_cnt_nxt = '0;
        if (!r_ve) begin
            case (r_ctrl)
                2'b00:   w_sym = 10'b1101010100;
                2'b01:   w_sym = 10'b0010101011;
                2'b10:   w_sym = 10'b0101010100;
                default: w_sym = 10'b1010101011;
            endcase
        end else begin
            unique case (1'b1)
                w_case_a: begin
                    w_sym = {~r_qm[8], r_qm[8],
                             r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
                    w_cnt_nxt = r_qm[8] ? r_cnt + w_diff
                                        : r_cnt - w_diff;
                end
                w_case_b: begin
                    w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
                    w_cnt_nxt = r_cnt + w_q8x2 - w_diff;
                end
                default: begin
                    w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
                    w_cnt_nxt = r_cnt + w_diff - w_nq8x2;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_out <= '0;
            r_cnt <= '0;
        end else begin
            r_out <= w_sym;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign bus.tmds_out = r_out;
    assign bus.cnt      = r_cnt;
endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: reference encoder/decoder model,
// directed control/data symbols, random stream with blanking and resets.
module tb_tmds_encoder;
    logic clk;
    logic rst;

    tmds_encoder_if bus ();

    tmds_encoder u_dut (
        .pixel_clk_in (clk),
        .rst_in       (rst),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]        sym;
        logic signed [4:0] cnt;
        int                due;
        logic              ve;
        logic [7:0]        d;
        logic [1:0]        c;
    } exp_t;

    exp_t sbq[$];
    exp_t e_mon;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   m_cnt = 0;
    bit   sb_on = 0;
    bit   rel_pend = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void enc(input logic ve, input logic [7:0] d,
                                input logic [1:0] c,
                                output logic [9:0] s,
                                output logic signed [4:0] k);
        int n1d, n1, n0;
        logic [8:0] q;
        s = '0;
        if (!ve) begin
            case (c)
                2'b00:   s = 10'b1101010100;
                2'b01:   s = 10'b0010101011;
                2'b10:   s = 10'b0101010100;
                default: s = 10'b1010101011;
            endcase
            m_cnt = 0;
        end else begin
            n1d = $countones(d);
            q = '0;
            q[0] = d[0];
            if (n1d > 4 || (n1d == 4 && !d[0])) begin
                for (int i = 1; i < 8; i++) q[i] = ~(q[i-1] ^ d[i]);
                q[8] = 1'b0;
            end else begin
                for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i];
                q[8] = 1'b1;
            end
            n1 = $countones(q[7:0]);
            n0 = 8 - n1;
            if (m_cnt == 0 || n1 == n0) begin
                s = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
                m_cnt += q[8] ? (n1 - n0) : (n0 - n1);
            end else if ((m_cnt > 0 && n1 > n0) ||
                         (m_cnt < 0 && n0 > n1)) begin
                s = {1'b1, q[8], ~q[7:0]};
                m_cnt += (q[8] ? 2 : 0) + n0 - n1;
            end else begin
                s = {1'b0, q[8], q[7:0]};
                m_cnt += n1 - n0 - (q[8] ? 0 : 2);
            end
        end
        k = 5'(m_cnt);
    endfunction

    function automatic void dec(input logic [9:0] s, output logic ve,
                                output logic [7:0] d,
                                output logic [1:0] c);
        logic [7:0] x;
        ve = 1'b1;
        d  = '0;
        c  = '0;
        case (s)
            10'b1101010100: begin ve = 1'b0; c = 2'b00; end
            10'b0010101011: begin ve = 1'b0; c = 2'b01; end
            10'b0101010100: begin ve = 1'b0; c = 2'b10; end
            10'b1010101011: begin ve = 1'b0; c = 2'b11; end
            default: begin
                x = s[9] ? ~s[7:0] : s[7:0];
                d[0] = x[0];
                for (int i = 1; i < 8; i++)
                    d[i] = s[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
            end
        endcase
    endfunction

    always @(posedge clk) begin
        logic       dve;
        logic [7:0] dd;
        logic [1:0] dc;
        int         sc;
        #1;
        cyc++;
        if (sb_on && sbq.size() > 0 && sbq[0].due <= cyc) begin
            e_mon = sbq.pop_front();
            check("sb_due", cyc, e_mon.due);
            check("sym", bus.tmds_out, e_mon.sym);
            check("cnt", bus.cnt, e_mon.cnt);
            dec(bus.tmds_out, dve, dd, dc);
            check("rt_ve", dve, e_mon.ve);
            if (e_mon.ve) begin
                check("rt_data", dd, e_mon.d);
                sc = int'(bus.cnt);
                check("disp_rng", (sc >= -10 && sc <= 10), 1);
            end else begin
                check("rt_ctl", dc, e_mon.c);
            end
        end
    end

    task automatic step_x(input logic ve, input logic [7:0] d,
                          input logic [1:0] c, input bit use_k,
                          input logic [9:0] ks,
                          input logic signed [4:0] kc);
        logic [9:0]        s;
        logic signed [4:0] k;
        @(negedge clk);
        if (rel_pend) begin
            rst = 1'b0;
            rel_pend = 0;
            sbq.push_back('{sym: 10'b1101010100, cnt: 5'sd0,
                            due: cyc + 1, ve: 1'b0, d: 8'h00, c: 2'b00});
            sb_on = 1;
        end
        bus.ve_in = ve;
        bus.data_in = d;
        bus.control_in = c;
        enc(ve, d, c, s, k);
        if (use_k) begin
            s = ks;
            k = kc;
        end
        sbq.push_back('{sym: s, cnt: k, due: cyc + 2,
                        ve: ve, d: d, c: c});
    endtask

    task automatic step(input logic ve, input logic [7:0] d,
                        input logic [1:0] c);
        step_x(ve, d, c, 0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        sb_on = 0;
        sbq.delete();
        @(negedge clk);
        rst = 1'b1;
        bus.ve_in = 1'b1;
        bus.data_in = 8'hFF;
        bus.control_in = 2'b11;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_out", bus.tmds_out, 10'd0);
            check("rst_cnt", bus.cnt, 5'sd0);
        end
        m_cnt = 0;
        rel_pend = 1;
    endtask

    initial begin
        rst = 1'b1;
        bus.ve_in = 1'b0;
        bus.data_in = 8'h00;
        bus.control_in = 2'b00;

        do_reset(3);
        step_x(0, 8'h5A, 2'b00, 1, 10'b1101010100, 5'sd0);
        step_x(0, 8'hA5, 2'b01, 1, 10'b0010101011, 5'sd0);
        step_x(0, 8'h33, 2'b10, 1, 10'b0101010100, 5'sd0);
        step_x(0, 8'hCC, 2'b11, 1, 10'b1010101011, 5'sd0);

        step_x(1, 8'hFF, 2'b00, 1, 10'b1000000000, -5'sd8);
        step_x(1, 8'hFF, 2'b00, 1, 10'b0011111111, -5'sd2);
        step_x(0, 8'hFF, 2'b00, 1, 10'b1101010100, 5'sd0);

        repeat (3) step(1, 8'h00, 2'b00);
        step(1, 8'h10, 2'b00);
        step(1, 8'hF0, 2'b00);
        step(1, 8'h0F, 2'b00);
        step(0, 8'h00, 2'b11);

        for (int i = 0; i < 5000; i++)
            step($urandom_range(0, 7) != 0, 8'($urandom),
                 2'($urandom));

        do_reset(2);
        for (int i = 0; i < 5000; i++)
            step($urandom_range(0, 7) != 0, 8'($urandom),
                 2'($urandom));

        repeat (4) @(posedge clk);
        #2;
        check("drain", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
